// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES round sequencer.
package aes_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StKexp,
    StInit,
    StRound,
    StFinal,
    StDone
  } aes_state_e;

  localparam int unsigned ROUND_W          = 4;
  localparam int unsigned KEXP_CYCLES_DEF  = 15;

  // Number of AES rounds for a key of nk 32-bit words.
  function automatic int unsigned aes_nr(input int unsigned nk);
    return nk + 32'd6;
  endfunction

endpackage

// File: rtl/aes_round_sequencer_arb.sv
// Two-way round-robin arbiter: picks a winner and computes the next pointer.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rr,
  input  logic       advance,
  input  logic [1:0] owner,
  output logic [1:0] winner,
  output logic       rr_next
);

  // Winner selection and pointer update; the pointer moves past the finished owner.
  always_comb begin
    winner  = req;
    rr_next = rr;
    if (req == 2'b11) begin
      winner = rr ? 2'b10 : 2'b01;
    end
    if (advance) begin
      if (owner[0]) begin
        rr_next = 1'b1;
      end else if (owner[1]) begin
        rr_next = 1'b0;
      end
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Control FSM for a shared iterative AES round datapath with two requesters.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned Nk          = 8,
  parameter int unsigned KEXP_CYCLES = KEXP_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [1:0]         key_inval,
  output logic [1:0]         gnt,
  output logic               busy,
  output logic               kexp_start,
  output logic               kexp_sel,
  output logic [ROUND_W-1:0] round,
  output logic               ld_first,
  output logic               ld_round,
  output logic               ld_last,
  output logic [1:0]         done
);

  localparam int unsigned       Nr       = aes_nr(Nk);
  localparam logic [ROUND_W-1:0] RoundMax = ROUND_W'(Nr);
  localparam logic [ROUND_W-1:0] RoundPen = ROUND_W'(Nr - 1);
  localparam logic [4:0]         KexpLast = 5'(KEXP_CYCLES - 1);

  aes_state_e         state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [4:0]         kcnt_q, kcnt_d;
  logic               key_loaded_q, key_loaded_d;
  logic               key_owner_q, key_owner_d;
  logic               rr_q, rr_d;
  logic               kexp_start_q, kexp_start_d;
  logic [1:0]         done_q, done_d;

  logic [1:0] winner;
  logic       rr_next;
  logic       advance;
  logic       inval_owner;

  rr_arbiter2 u_arb (
    .req     (req),
    .rr      (rr_q),
    .advance (advance),
    .owner   (done_q),
    .winner  (winner),
    .rr_next (rr_next)
  );

  assign inval_owner = key_inval[key_owner_q];

  // Next-state logic for the sequencer and its cached-key bookkeeping.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    round_d      = round_q;
    kcnt_d       = kcnt_q;
    key_loaded_d = key_loaded_q;
    key_owner_d  = key_owner_q;
    kexp_start_d = 1'b0;
    done_d       = 2'b00;
    advance      = 1'b0;

    // A stale key is forgotten in any state; an in-flight operation keeps its key.
    if (inval_owner) begin
      key_loaded_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d = winner;
          if (key_loaded_q && !inval_owner && (key_owner_q == winner[1])) begin
            state_d = StInit;
          end else begin
            key_owner_d  = winner[1];
            key_loaded_d = 1'b0;
            kexp_start_d = 1'b1;
            kcnt_d       = 5'd0;
            state_d      = StKexp;
          end
        end
      end
      StKexp: begin
        if (inval_owner) begin
          // Key changed under the expander: restart it from scratch.
          kexp_start_d = 1'b1;
          kcnt_d       = 5'd0;
        end else if (kcnt_q == KexpLast) begin
          key_loaded_d = 1'b1;
          state_d      = StInit;
        end else begin
          kcnt_d = kcnt_q + 5'd1;
        end
      end
      StInit: begin
        round_d = ROUND_W'(1);
        state_d = StRound;
      end
      StRound: begin
        if (round_q == RoundPen) begin
          round_d = RoundMax;
          state_d = StFinal;
        end else begin
          round_d = round_q + ROUND_W'(1);
        end
      end
      StFinal: begin
        done_d  = gnt_q;
        gnt_d   = 2'b00;
        state_d = StDone;
      end
      StDone: begin
        advance = 1'b1;
        round_d = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign rr_d = rr_next;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      gnt_q        <= 2'b00;
      round_q      <= '0;
      kcnt_q       <= 5'd0;
      key_loaded_q <= 1'b0;
      key_owner_q  <= 1'b0;
      rr_q         <= 1'b0;
      kexp_start_q <= 1'b0;
      done_q       <= 2'b00;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      round_q      <= round_d;
      kcnt_q       <= kcnt_d;
      key_loaded_q <= key_loaded_d;
      key_owner_q  <= key_owner_d;
      rr_q         <= rr_d;
      kexp_start_q <= kexp_start_d;
      done_q       <= done_d;
    end
  end

  assign gnt        = gnt_q;
  assign busy       = (state_q != StIdle);
  assign kexp_start = kexp_start_q;
  assign kexp_sel   = key_owner_q;
  assign round      = round_q;
  assign ld_first   = (state_q == StInit);
  assign ld_round   = (state_q == StRound);
  assign ld_last    = (state_q == StFinal);
  assign done       = done_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer (Nk=8 and Nk=4 instances).
module tb_aes_round_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req8 = 2'b00, kinv8 = 2'b00, req4 = 2'b00, kinv4 = 2'b00;

  logic [1:0] gnt8, done8, gnt4, done4;
  logic       busy8, kst8, sel8, ldf8, ldr8, ldl8;
  logic       busy4, kst4, sel4, ldf4, ldr4, ldl4;
  logic [3:0] round8, round4;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic use4 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_sequencer #(.Nk(8), .KEXP_CYCLES(15)) dut8 (
    .clk(clk), .rst(rst), .req(req8), .key_inval(kinv8), .gnt(gnt8), .busy(busy8),
    .kexp_start(kst8), .kexp_sel(sel8), .round(round8), .ld_first(ldf8),
    .ld_round(ldr8), .ld_last(ldl8), .done(done8)
  );

  aes_round_sequencer #(.Nk(4), .KEXP_CYCLES(15)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .key_inval(kinv4), .gnt(gnt4), .busy(busy4),
    .kexp_start(kst4), .kexp_sel(sel4), .round(round4), .ld_first(ldf4),
    .ld_round(ldr4), .ld_last(ldl4), .done(done4)
  );

  // Observed view of whichever instance is under test.
  logic [1:0] m_gnt, m_done;
  logic       m_kst, m_sel, m_ldf, m_ldr, m_ldl;
  logic [3:0] m_round;
  assign m_gnt   = use4 ? gnt4 : gnt8;
  assign m_done  = use4 ? done4 : done8;
  assign m_kst   = use4 ? kst4 : kst8;
  assign m_sel   = use4 ? sel4 : sel8;
  assign m_ldf   = use4 ? ldf4 : ldf8;
  assign m_ldr   = use4 ? ldr4 : ldr8;
  assign m_ldl   = use4 ? ldl4 : ldl8;
  assign m_round = use4 ? round4 : round8;

  // Results collected by observe().
  int o_kst_first, o_kst_last, o_kst_cnt, o_first_cyc, o_nround, o_last_round;
  int o_done_cyc, o_done_abs, o_max_round;
  logic [1:0] o_done_val, o_gnt1;
  logic o_sel1, o_seq_ok, o_strobe_ok, o_gnt_stable;

  // Called just after the edge that opens cycle 0; returns at the done cycle.
  task automatic observe(input int budget, input int inval_cyc, input logic [1:0] inval_val);
    int exp_round;
    o_kst_first = -1; o_kst_last = -1; o_kst_cnt = 0; o_first_cyc = -1; o_nround = 0;
    o_last_round = -1; o_done_cyc = -1; o_done_abs = -1; o_max_round = 0;
    o_done_val = 2'b00; o_gnt1 = 2'b00; o_sel1 = 1'b0;
    o_seq_ok = 1'b1; o_strobe_ok = 1'b1; o_gnt_stable = 1'b1;
    exp_round = 1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == 1) begin
        o_gnt1 = m_gnt;
        o_sel1 = m_sel;
      end
      if (m_kst) begin
        if (o_kst_cnt == 0) o_kst_first = c;
        o_kst_last = c;
        o_kst_cnt++;
      end
      if (m_ldf) begin
        o_first_cyc = c;
        if (m_round !== 4'd0) o_seq_ok = 1'b0;
      end
      if (m_ldr) begin
        o_nround++;
        if (int'(m_round) != exp_round) o_seq_ok = 1'b0;
        exp_round++;
      end
      if (m_ldl) o_last_round = int'(m_round);
      if (int'(m_round) > o_max_round) o_max_round = int'(m_round);
      if ($countones({m_ldf, m_ldr, m_ldl}) > 1) o_strobe_ok = 1'b0;
      if (c >= 1 && m_done == 2'b00 && m_gnt !== o_gnt1) o_gnt_stable = 1'b0;
      if (use4) kinv4 = (c == inval_cyc) ? inval_val : 2'b00;
      else      kinv8 = (c == inval_cyc) ? inval_val : 2'b00;
      if (m_done != 2'b00) begin
        o_done_cyc = c;
        o_done_val = m_done;
        o_done_abs = cyc;
        if (m_gnt !== 2'b00) o_gnt_stable = 1'b0;
        break;
      end
    end
    kinv8 = 2'b00;
    kinv4 = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({gnt8, busy8, kst8, sel8, round8, ldf8, ldr8, ldl8, done8} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_n8: outputs=%h required 0", {gnt8, busy8, kst8, sel8, round8,
               ldf8, ldr8, ldl8, done8});
    end
    n_checks++;
    if ({gnt4, busy4, kst4, sel4, round4, ldf4, ldr4, ldl4, done4} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_n4: outputs=%h required 0", {gnt4, busy4, kst4, sel4, round4,
               ldf4, ldr4, ldl4, done4});
    end
  endtask

  task automatic test_first_expansion();
    @(posedge clk); #1;
    rst = 1'b1;
    req8 = 2'b01;
    observe(80, -1, 2'b00);
    req8 = 2'b00;
    n_checks++;
    if (o_kst_first != 1 || o_kst_cnt != 1) begin
      n_fail++;
      $display("FAIL exp_kstart: at %0d count %0d, required at 1 count 1", o_kst_first, o_kst_cnt);
    end
    n_checks++;
    if (o_gnt1 !== 2'b01 || o_sel1 !== 1'b0) begin
      n_fail++;
      $display("FAIL exp_gnt: gnt=%b sel=%b, required 01/0", o_gnt1, o_sel1);
    end
    n_checks++;
    if (o_first_cyc != 16) begin
      n_fail++;
      $display("FAIL exp_ld_first: cycle %0d, required 16", o_first_cyc);
    end
    n_checks++;
    if (o_nround != 13 || !o_seq_ok || !o_strobe_ok) begin
      n_fail++;
      $display("FAIL exp_rounds: n=%0d seq=%b onehot=%b, required 13/1/1", o_nround, o_seq_ok,
               o_strobe_ok);
    end
    n_checks++;
    if (o_last_round != 14) begin
      n_fail++;
      $display("FAIL exp_ld_last: round %0d, required 14", o_last_round);
    end
    n_checks++;
    if (o_done_cyc != 31 || o_done_val !== 2'b01 || !o_gnt_stable) begin
      n_fail++;
      $display("FAIL exp_done: cycle %0d val %b gnt_ok %b, required 31/01/1", o_done_cyc,
               o_done_val, o_gnt_stable);
    end
  endtask

  task automatic test_cached_key();
    @(posedge clk); #1;
    req8 = 2'b01;
    observe(80, -1, 2'b00);
    req8 = 2'b00;
    n_checks++;
    if (o_kst_cnt != 0 || o_first_cyc != 1) begin
      n_fail++;
      $display("FAIL cached_skip: kstarts %0d ld_first %0d, required 0/1", o_kst_cnt, o_first_cyc);
    end
    n_checks++;
    if (o_done_cyc != 16 || o_done_val !== 2'b01) begin
      n_fail++;
      $display("FAIL cached_done: cycle %0d val %b, required 16/01", o_done_cyc, o_done_val);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g [3];
    int prev_abs;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    prev_abs = -1;
    rst = 1'b0;
    req8 = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      observe(80, -1, 2'b00);
      n_checks++;
      if (o_gnt1 !== exp_g[k] || o_done_val !== exp_g[k] || o_sel1 !== exp_g[k][1]) begin
        n_fail++;
        $display("FAIL b2b_grant%0d: gnt=%b done=%b sel=%b, required %b", k, o_gnt1,
                 o_done_val, o_sel1, exp_g[k]);
      end
      n_checks++;
      if (o_done_cyc != 31 || o_kst_cnt != 1 || !o_gnt_stable) begin
        n_fail++;
        $display("FAIL b2b_timing%0d: done %0d kstarts %0d gnt_ok %b, required 31/1/1", k,
                 o_done_cyc, o_kst_cnt, o_gnt_stable);
      end
      if (k > 0) begin
        n_checks++;
        if (o_done_abs - prev_abs != 32) begin
          n_fail++;
          $display("FAIL b2b_gap%0d: %0d cycles, required 32", k, o_done_abs - prev_abs);
        end
      end
      prev_abs = o_done_abs;
    end
    req8 = 2'b00;
  endtask

  task automatic test_key_inval();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    req8 = 2'b01;
    observe(80, 5, 2'b01);
    req8 = 2'b00;
    n_checks++;
    if (o_kst_first != 1 || o_kst_last != 6 || o_kst_cnt != 2) begin
      n_fail++;
      $display("FAIL inval_restart: first %0d last %0d count %0d, required 1/6/2", o_kst_first,
               o_kst_last, o_kst_cnt);
    end
    n_checks++;
    if (o_first_cyc != 21 || o_done_cyc != 36) begin
      n_fail++;
      $display("FAIL inval_delay: ld_first %0d done %0d, required 21/36", o_first_cyc, o_done_cyc);
    end
  endtask

  task automatic test_reset_mid_op();
    bit found;
    found = 1'b0;
    @(posedge clk); #1;
    req8 = 2'b01;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (ldr8 && round8 == 4'd7) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL rstmid_reach: round 7 not seen, round=%0d", round8);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({gnt8, busy8, kst8, sel8, round8, ldf8, ldr8, ldl8, done8} !== 15'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: outputs=%h required 0", {gnt8, busy8, kst8, sel8, round8,
               ldf8, ldr8, ldl8, done8});
    end
    req8 = 2'b00;
    @(negedge clk);
    n_checks++;
    if (done8 !== 2'b00 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_nodone: done=%b busy=%b, required 00/0", done8, busy8);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    req8 = 2'b10;
    observe(80, -1, 2'b00);
    req8 = 2'b00;
    n_checks++;
    if (o_kst_cnt != 1 || o_sel1 !== 1'b1 || o_done_cyc != 31 || o_done_val !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_reexp: kstarts %0d sel %b done %0d val %b, required 1/1/31/10",
               o_kst_cnt, o_sel1, o_done_cyc, o_done_val);
    end
  endtask

  task automatic test_nk4();
    int prev_abs;
    use4 = 1'b1;
    @(posedge clk); #1;
    req4 = 2'b01;
    observe(80, -1, 2'b00);
    prev_abs = o_done_abs;
    n_checks++;
    if (o_done_cyc != 27 || o_kst_cnt != 1 || o_nround != 9 || o_last_round != 10) begin
      n_fail++;
      $display("FAIL nk4_expand: done %0d kstarts %0d rounds %0d last %0d, required 27/1/9/10",
               o_done_cyc, o_kst_cnt, o_nround, o_last_round);
    end
    // Request stays high through done: the following IDLE cycle starts a new operation.
    @(posedge clk); #1;
    observe(80, -1, 2'b00);
    req4 = 2'b00;
    n_checks++;
    if (o_done_cyc != 12 || o_kst_cnt != 0 || o_done_val !== 2'b01) begin
      n_fail++;
      $display("FAIL nk4_cached: done %0d kstarts %0d val %b, required 12/0/01", o_done_cyc,
               o_kst_cnt, o_done_val);
    end
    n_checks++;
    if (o_max_round != 10 || !o_seq_ok || !o_strobe_ok) begin
      n_fail++;
      $display("FAIL nk4_round_max: max %0d seq %b onehot %b, required 10/1/1", o_max_round,
               o_seq_ok, o_strobe_ok);
    end
    n_checks++;
    if (o_done_abs - prev_abs != 13) begin
      n_fail++;
      $display("FAIL nk4_gap: %0d cycles, required 13", o_done_abs - prev_abs);
    end
    use4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_expansion();
    test_cached_key();
    test_back_to_back();
    test_key_inval();
    test_reset_mid_op();
    test_nk4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Control FSM for one shared iterative AES round datapath: AddRoundKey, SubBytes/ShiftRows/MixColumns, final round and key expansion. Two requesters contend for the core through a round-robin arbiter. The block times key expansion, skipping it when the expanded key already belongs to the granted requester, and steps the round index. It drives the datapath load strobes and returns a per-requester completion pulse.

## Interface
- `Nk`, default 8, key length in 32-bit words. Legal values: 4, 6, 8.
- `Nr`, localparam, equal to `Nk+6` (10, 12 or 14).
- `KEXP_CYCLES`, default 15, cycles the key expander needs after its restart pulse. Legal range 1–31.
- `clk`  in  1  single clock; everything is updated on the rising edge.
- `rst`  in  1  synchronous reset, active-low: 0 resets on the next rising edge.
- `req`  in  2  per-requester encrypt request. Held high until the matching `done`.
- `key_inval`  in  2  one-cycle pulse: the requester changed its key, so its cached expansion is stale.
- `gnt`  out  2  one-hot grant, or 0. Steers the datapath input and key muxes.
- `busy`  out  1  high in every state except IDLE.
- `kexp_start`  out  1  one-cycle pulse that restarts the key expander.
- `kexp_sel`  out  1  index of the requester whose key feeds the expander.
- `round`  out  4  current round index, 0..Nr.
- `ld_first`  out  1  load state register with (plaintext XOR round key 0).
- `ld_round`  out  1  load state register with the full-round result.
- `ld_last`  out  1  load output register with the final-round result (no MixColumns).
- `done`  out  2  one-cycle pulse to the granted requester; output register is valid.

## Operation
- Registered state: FSM state, `gnt`, `round`, 5-bit KEXP counter, `key_loaded`, `key_owner`, round-robin pointer `rr`.
- Reset values: every output 0, `key_loaded`=0, `rr`=0 (requester 0 has priority), state IDLE.
- IDLE
  - No `req`: stay in IDLE.
  - Any `req`: grant by round-robin. If both request, the winner is `rr`; otherwise the single requester wins.
  - If `key_loaded` and `key_owner`==winner, go to INIT. Otherwise set `kexp_sel`/`key_owner` to the winner, pulse `kexp_start`, clear the counter and go to KEXP.
- KEXP: counter increments each cycle. When it reaches KEXP_CYCLES-1, set `key_loaded`=1 and go to INIT.
- INIT: `round`=0, `ld_first`=1, for 1 cycle. Then go to ROUND with `round`=1.
- ROUND
  - `ld_round`=1 for each `round` in 1..Nr-1, with `round` incrementing.
  - After `round`=Nr-1, set `round`=Nr and go to FINAL.
- FINAL: `ld_last`=1, for 1 cycle. Then go to DONE.
- DONE
  - `done[g]`=1 and `gnt` cleared, for 1 cycle.
  - `rr` moves to the other requester, `round`=0, return to IDLE.
- Exactly one of `ld_first`/`ld_round`/`ld_last` is high in INIT/ROUND/FINAL. All three are 0 elsewhere.
- `key_inval[i]` is honoured in every state.
  - If i==`key_owner`, clear `key_loaded`.
  - If this happens during KEXP for that owner, restart the expansion: re-pulse `kexp_start` and clear the counter.
  - If it happens in INIT/ROUND/FINAL, the current operation finishes with the old key. The next grant to i re-expands.
- `req` dropping mid-operation is ignored; no abort. The sequence completes and `done` still pulses.
- A `req` still high in the cycle after `done` counts as a new request.
- `round` arithmetic: 4-bit unsigned, never exceeds Nr, never wraps.

## Timing
- Cycle 0 is IDLE with `req` sampled. `gnt` is visible from cycle 1.
- Cached key:
  - INIT at cycle 1.
  - ROUND at cycles 2..Nr.
  - FINAL at Nr+1.
  - `done` at Nr+2. For Nr=14 that is cycle 16.
- Key expansion needed:
  - `kexp_start` at cycle 1.
  - KEXP at cycles 1..KEXP_CYCLES.
  - INIT at KEXP_CYCLES+1.
  - `done` at KEXP_CYCLES+Nr+2. Defaults give cycle 31.
- Back-to-back: the next grant is evaluated in the IDLE cycle after DONE. The minimum gap between `done` pulses is Nr+3 cycles.
- Reset mid-operation: all outputs are 0 on the next edge. No `done` is emitted for the aborted request.

## Structure
- Shared package `aes_pkg`:
  - state enum (IDLE, KEXP, INIT, ROUND, FINAL, DONE)
  - function `aes_nr(Nk)`
  - `ROUND_W`=4
  - default `KEXP_CYCLES`
- Sub-module `rr_arbiter2`: two-way round-robin. Inputs are `req`, `rr` and the advance pulse; outputs are the one-hot winner and the next pointer.
- The datapath is outside this block. This block only drives the muxes and strobes.

## Test plan
- Reset, then `req`=01 with Nk=8: `kexp_start` at cycle 1, `ld_first` at 16, `ld_round` for `round` 1..13, `ld_last` at `round`=14, `done`=01 at cycle 31.
- Repeat `req`=01: no `kexp_start`, and `done`=01 at cycle 16.
- `req`=11 held from reset: grants go 01, 10, 01, each with re-expansion. `done` pulses alternate. Nothing is granted while busy.
- `key_inval[0]` at cycle 5 of a KEXP for requester 0: `kexp_start` re-pulses at cycle 6, and `done` is delayed by 5 cycles.
- `rst`=0 during ROUND with `round`=7: next edge gives all outputs 0 and state IDLE. A subsequent `req`=10 re-expands the key.
- Nk=4: `done` at cycle 12 with a cached key. `round` never exceeds 10.
